// File: rtl/sequence_pattern_tx.sv
// ============================================================================
// Module      : sequence_pattern_tx
// Description : Serial pattern transmitter. Sends a latched PAT_W-bit pattern
//               MSB first, repeated a programmable number of times with idle
//               gaps between repetitions, with bit-advance enable, abort and
//               a one-cycle completion pulse. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sequence_pattern_tx #(
   parameter int               PAT_W       = 6,
   parameter logic [PAT_W-1:0] DEF_PATTERN = 6'b010110,
   parameter int               GAP_CYCLES  = 2
) (
   input  logic             clk,
   input  logic             reset,        // asynchronous, active low
   input  logic             start,
   input  logic             use_default,
   input  logic [PAT_W-1:0] pattern_in,
   input  logic [3:0]       repeat_cnt,
   input  logic             tx_en,
   input  logic             abort,
   output logic             x,
   output logic             valid,
   output logic             busy,
   output logic             done,
   output logic [2:0]       state
);

   localparam int               IDX_W      = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(PAT_W - 1);
   localparam logic [3:0]       c_GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
   localparam bit               c_NO_GAP   = (GAP_CYCLES == 0);

   typedef enum logic [2:0] {
      S_IDLE = 3'b000,
      S_SEND = 3'b001,
      S_GAP  = 3'b010,
      S_DONE = 3'b011
   } state_e;

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d;        // pattern latched at start
   logic [PAT_W-1:0]   sh_q, sh_d;          // shift register, MSB is next x
   logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
   logic [3:0]         reps_left_q, reps_left_d;
   logic [3:0]         gap_q, gap_d;
   logic               x_q, x_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic [PAT_W-1:0]   w_start_pat;

   assign w_start_pat = use_default ? DEF_PATTERN : pattern_in;

   // Next-state and next-output logic; outputs are computed one cycle ahead
   // so that x/valid/busy/done come straight from flops.
   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      sh_d        = sh_q;
      bit_idx_d   = bit_idx_q;
      reps_left_d = reps_left_q;
      gap_d       = gap_q;
      x_d         = 1'b0;
      valid_d     = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // A simultaneous abort cancels the request before it is taken.
            if (start && !abort) begin
               state_d     = S_SEND;
               pat_d       = w_start_pat;
               sh_d        = w_start_pat;
               bit_idx_d   = '0;
               reps_left_d = (repeat_cnt == 4'd0) ? 4'd1 : repeat_cnt;
               gap_d       = 4'd0;
               x_d         = w_start_pat[PAT_W-1];
               valid_d     = 1'b1;
               busy_d      = 1'b1;
            end
         end

         S_SEND: begin
            if (abort) begin
               state_d     = S_IDLE;
               bit_idx_d   = '0;
               reps_left_d = 4'd0;
            end else if (!tx_en) begin
               // Stall: hold the bit currently on the line.
               x_d     = x_q;
               valid_d = valid_q;
               busy_d  = 1'b1;
            end else if (bit_idx_q == c_LAST_IDX) begin
               busy_d = 1'b1;
               if (reps_left_q > 4'd1) begin
                  reps_left_d = reps_left_q - 4'd1;
                  if (c_NO_GAP) begin
                     // No idle gap: reload and start the next repetition now.
                     sh_d      = pat_q;
                     bit_idx_d = '0;
                     x_d       = pat_q[PAT_W-1];
                     valid_d   = 1'b1;
                  end else begin
                     state_d = S_GAP;
                     gap_d   = 4'd0;
                  end
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end
            end else begin
               bit_idx_d = bit_idx_q + IDX_W'(1);
               sh_d      = {sh_q[PAT_W-2:0], 1'b0};
               x_d       = sh_q[PAT_W-2];
               valid_d   = 1'b1;
               busy_d    = 1'b1;
            end
         end

         S_GAP: begin
            if (abort) begin
               state_d     = S_IDLE;
               bit_idx_d   = '0;
               reps_left_d = 4'd0;
               gap_d       = 4'd0;
            end else begin
               busy_d = 1'b1;
               // Gap time only elapses on enabled bit-times.
               if (tx_en) begin
                  if (gap_q == c_GAP_LAST) begin
                     state_d   = S_SEND;
                     sh_d      = pat_q;
                     bit_idx_d = '0;
                     gap_d     = 4'd0;
                     x_d       = pat_q[PAT_W-1];
                     valid_d   = 1'b1;
                  end else begin
                     gap_d = gap_q + 4'd1;
                  end
               end
            end
         end

         S_DONE: begin
            state_d     = S_IDLE;
            bit_idx_d   = '0;
            reps_left_d = 4'd0;
         end

         default: begin
            // Illegal encodings fall back to IDLE on the next edge.
            state_d     = S_IDLE;
            bit_idx_d   = '0;
            reps_left_d = 4'd0;
            gap_d       = 4'd0;
         end
      endcase
   end

   // State and output registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         pat_q       <= '0;
         sh_q        <= '0;
         bit_idx_q   <= '0;
         reps_left_q <= 4'd0;
         gap_q       <= 4'd0;
         x_q         <= 1'b0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         sh_q        <= sh_d;
         bit_idx_q   <= bit_idx_d;
         reps_left_q <= reps_left_d;
         gap_q       <= gap_d;
         x_q         <= x_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign x     = x_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_sequence_pattern_tx.sv
// ============================================================================
// Module      : tb_sequence_pattern_tx
// Description : Self-checking bench for sequence_pattern_tx. Expected serial
//               bits are queued when a transmission is launched and compared
//               against bits captured while valid is high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sequence_pattern_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       use_default;
   logic [5:0] pattern_in;
   logic [3:0] repeat_cnt;
   logic       tx_en;
   logic       abort;
   logic       x, valid, busy, done;
   logic [2:0] state;

   int   tests  = 0;
   int   failed = 0;
   logic exp_q[$];
   logic obs_q[$];
   int   n_done, n_busy, n_gap;
   logic [5:0] det_sh;
   int   det_n, det_hits;

   sequence_pattern_tx #(
      .PAT_W      (6),
      .DEF_PATTERN(6'b010110),
      .GAP_CYCLES (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .use_default(use_default),
      .pattern_in (pattern_in),
      .repeat_cnt (repeat_cnt),
      .tx_en      (tx_en),
      .abort      (abort),
      .x          (x),
      .valid      (valid),
      .busy       (busy),
      .done       (done),
      .state      (state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog");
   end

   // One clock: sample outputs on the falling edge, then return 1 time unit
   // after the next rising edge so inputs change away from it.
   task automatic tick();
      @(negedge clk);
      if (valid) begin
         obs_q.push_back(x);
         det_sh = {det_sh[4:0], x};
         det_n++;
         if (det_n >= 6 && det_sh == 6'b010110) det_hits++;
      end
      if (done) n_done++;
      if (busy) n_busy++;
      if (busy && !valid && !done) n_gap++;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      obs_q.delete();
      exp_q.delete();
      n_done = 0; n_busy = 0; n_gap = 0;
      det_sh = 6'd0; det_n = 0; det_hits = 0;
   endtask

   task automatic push_pat(input logic [5:0] p, input int reps);
      for (int r = 0; r < reps; r++)
         for (int i = 5; i >= 0; i--) exp_q.push_back(p[i]);
   endtask

   task automatic pulse_start(input logic ud, input logic [5:0] p, input logic [3:0] rc);
      use_default = ud; pattern_in = p; repeat_cnt = rc;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int c = 0;
      while (busy && c < 200) begin tick(); c++; end
      tests++;
      if (busy) begin
         failed++;
         $display("FAIL %s timeout: busy got %b want 0 within 200 cycles", name, busy);
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      tests++;
      if ({x, valid, busy, done, state} !== 7'd0) begin
         failed++;
         $display("FAIL reset_outputs: got %b want 0000000", {x, valid, busy, done, state});
      end
      reset = 1'b1;
      tick();
      tests++;
      if (state !== 3'b000 || busy !== 1'b0) begin
         failed++;
         $display("FAIL reset_release_idle: state got %b want 000, busy got %b want 0", state, busy);
      end
   endtask

   task automatic test_default();
      logic e, o;
      clear_mon();
      push_pat(6'b010110, 1);
      pulse_start(1'b1, 6'b000000, 4'd1);
      tests++;
      if (state !== 3'b001 || valid !== 1'b1 || x !== 1'b0 || busy !== 1'b1) begin
         failed++;
         $display("FAIL default_first: state/valid/x/busy got %b/%b/%b/%b want 001/1/0/1", state, valid, x, busy);
      end
      wait_idle("default");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz; tests++;
         if (o !== e) begin failed++; $display("FAIL default_bit: got %b want %b", o, e); end
      end
      tests++;
      if (obs_q.size() != 0) begin failed++; $display("FAIL default_extra: got %0d want 0", obs_q.size()); end
      tests++;
      if (n_done != 1 || n_busy != 7 || n_gap != 0) begin
         failed++;
         $display("FAIL default_counts: done/busy/gap got %0d/%0d/%0d want 1/7/0", n_done, n_busy, n_gap);
      end
      tests++;
      if (state !== 3'b000) begin failed++; $display("FAIL default_idle: got %b want 000", state); end
   endtask

   task automatic test_user_repeat();
      logic e, o;
      clear_mon();
      push_pat(6'b111001, 2);
      pulse_start(1'b0, 6'b111001, 4'd2);
      wait_idle("user_repeat");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz; tests++;
         if (o !== e) begin failed++; $display("FAIL user_repeat_bit: got %b want %b", o, e); end
      end
      tests++;
      if (obs_q.size() != 0) begin failed++; $display("FAIL user_repeat_extra: got %0d want 0", obs_q.size()); end
      tests++;
      if (n_done != 1 || n_busy != 15 || n_gap != 2) begin
         failed++;
         $display("FAIL user_repeat_counts: done/busy/gap got %0d/%0d/%0d want 1/15/2", n_done, n_busy, n_gap);
      end
   endtask

   task automatic test_stall();
      logic e, o;
      clear_mon();
      exp_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      pulse_start(1'b1, 6'b000000, 4'd1);
      tick();
      tx_en = 1'b0;
      repeat (3) tick();
      tx_en = 1'b1;
      wait_idle("stall");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz; tests++;
         if (o !== e) begin failed++; $display("FAIL stall_bit: got %b want %b", o, e); end
      end
      tests++;
      if (obs_q.size() != 0) begin failed++; $display("FAIL stall_extra: got %0d want 0", obs_q.size()); end
      tests++;
      if (n_done != 1 || n_busy != 10) begin
         failed++;
         $display("FAIL stall_counts: done/busy got %0d/%0d want 1/10", n_done, n_busy);
      end
   endtask

   task automatic test_abort();
      logic e, o;
      clear_mon();
      exp_q = '{1'b1, 1'b0, 1'b1, 1'b1};
      pulse_start(1'b0, 6'b101101, 4'd3);
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tests++;
      if ({x, valid, busy, done, state} !== 7'd0) begin
         failed++;
         $display("FAIL abort_idle: got %b want 0000000", {x, valid, busy, done, state});
      end
      repeat (3) tick();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz; tests++;
         if (o !== e) begin failed++; $display("FAIL abort_bit: got %b want %b", o, e); end
      end
      tests++;
      if (obs_q.size() != 0 || n_done != 0) begin
         failed++;
         $display("FAIL abort_after: extra bits/done got %0d/%0d want 0/0", obs_q.size(), n_done);
      end
      clear_mon();
      push_pat(6'b010110, 1);
      pulse_start(1'b1, 6'b000000, 4'd1);
      wait_idle("abort_restart");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz; tests++;
         if (o !== e) begin failed++; $display("FAIL abort_restart_bit: got %b want %b", o, e); end
      end
      tests++;
      if (n_done != 1) begin failed++; $display("FAIL abort_restart_done: got %0d want 1", n_done); end
   endtask

   task automatic test_abort_start_idle();
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      tests++;
      if (state !== 3'b000 || busy !== 1'b0 || valid !== 1'b0) begin
         failed++;
         $display("FAIL abort_start_idle: state/busy/valid got %b/%b/%b want 000/0/0", state, busy, valid);
      end
   endtask

   task automatic test_reset_mid();
      logic e, o;
      clear_mon();
      exp_q = '{1'b0, 1'b1};
      pulse_start(1'b1, 6'b000000, 4'd1);
      repeat (2) tick();
      #2;
      reset = 1'b0;
      #1;
      tests++;
      if ({x, valid, busy, done, state} !== 7'd0) begin
         failed++;
         $display("FAIL reset_mid_immediate: got %b want 0000000", {x, valid, busy, done, state});
      end
      use_default = 1'b0; pattern_in = 6'b111001; repeat_cnt = 4'd1;
      start = 1'b1;
      repeat (2) tick();
      tests++;
      if (state !== 3'b000 || valid !== 1'b0) begin
         failed++;
         $display("FAIL reset_mid_held: state/valid got %b/%b want 000/0", state, valid);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz; tests++;
         if (o !== e) begin failed++; $display("FAIL reset_mid_bit: got %b want %b", o, e); end
      end
      tests++;
      if (obs_q.size() != 0) begin failed++; $display("FAIL reset_mid_extra: got %0d want 0", obs_q.size()); end
      push_pat(6'b111001, 1);
      reset = 1'b1;
      tick();
      start = 1'b0;
      tests++;
      if (state !== 3'b001 || valid !== 1'b1 || x !== 1'b1) begin
         failed++;
         $display("FAIL reset_first_start: state/valid/x got %b/%b/%b want 001/1/1", state, valid, x);
      end
      wait_idle("reset_restart");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz; tests++;
         if (o !== e) begin failed++; $display("FAIL reset_restart_bit: got %b want %b", o, e); end
      end
      tests++;
      if (n_done != 1) begin failed++; $display("FAIL reset_restart_done: got %0d want 1", n_done); end
   endtask

   task automatic test_ignore_start();
      logic e, o;
      clear_mon();
      push_pat(6'b010110, 1);
      pulse_start(1'b1, 6'b000000, 4'd1);
      repeat (2) tick();
      use_default = 1'b0; pattern_in = 6'b000000; repeat_cnt = 4'd5;
      start = 1'b1;
      repeat (2) tick();
      start = 1'b0;
      wait_idle("ignore_start");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz; tests++;
         if (o !== e) begin failed++; $display("FAIL ignore_start_bit: got %b want %b", o, e); end
      end
      tests++;
      if (obs_q.size() != 0 || n_done != 1 || n_busy != 7) begin
         failed++;
         $display("FAIL ignore_start_counts: extra/done/busy got %0d/%0d/%0d want 0/1/7", obs_q.size(), n_done, n_busy);
      end
   endtask

   task automatic test_repeat_zero_and_loopback();
      logic e, o;
      clear_mon();
      push_pat(6'b010110, 1);
      pulse_start(1'b1, 6'b000000, 4'd0);
      wait_idle("repeat_zero");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz; tests++;
         if (o !== e) begin failed++; $display("FAIL repeat_zero_bit: got %b want %b", o, e); end
      end
      tests++;
      if (obs_q.size() != 0 || det_hits != 1 || n_busy != 7) begin
         failed++;
         $display("FAIL repeat_zero_counts: extra/hits/busy got %0d/%0d/%0d want 0/1/7", obs_q.size(), det_hits, n_busy);
      end
      clear_mon();
      push_pat(6'b010110, 3);
      pulse_start(1'b1, 6'b000000, 4'd3);
      wait_idle("loopback3");
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 1'bz; tests++;
         if (o !== e) begin failed++; $display("FAIL loopback3_bit: got %b want %b", o, e); end
      end
      tests++;
      if (det_hits != 3 || n_gap != 4 || n_busy != 23 || n_done != 1) begin
         failed++;
         $display("FAIL loopback3_counts: hits/gap/busy/done got %0d/%0d/%0d/%0d want 3/4/23/1", det_hits, n_gap, n_busy, n_done);
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; use_default = 1'b0; pattern_in = 6'd0;
      repeat_cnt = 4'd0; tx_en = 1'b1; abort = 1'b0;
      clear_mon();
      test_reset();
      test_default();
      test_user_repeat();
      test_stall();
      test_abort();
      test_abort_start_idle();
      test_reset_mid();
      test_ignore_start();
      test_repeat_zero_and_loopback();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sequence_pattern_tx.md
SEQUENCE_PATTERN_TX -- requirements
Module: sequence_pattern_tx

Interface
REQ-001 Parameter PAT_W, default 6: pattern length in bits.
REQ-002 Parameter DEF_PATTERN, default 6'b010110: built-in pattern, MSB first.
REQ-003 Parameter GAP_CYCLES, default 2: idle bit-times between repetitions, range 0..15.
REQ-004 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1: asynchronous, active-low reset (asserted at 0).
REQ-006 Port start  input  1: request a transmission; sampled only in IDLE.
REQ-007 Port use_default  input  1: at start, 1 selects DEF_PATTERN and 0 selects pattern_in.
REQ-008 Port pattern_in  input  PAT_W: user pattern; latched at accepted start.
REQ-009 Port repeat_cnt  input  4: number of repetitions, latched at accepted start; 0 is treated as 1.
REQ-010 Port tx_en  input  1: bit-advance enable; 0 stalls the current bit.
REQ-011 Port abort  input  1: synchronous cancel of an active transmission.
REQ-012 Port x  output  1: registered serial data, MSB of the pattern first.
REQ-013 Port valid  output  1: registered; 1 while x carries a pattern bit.
REQ-014 Port busy  output  1: registered; 1 in any state other than IDLE.
REQ-015 Port done  output  1: registered one-cycle pulse on normal completion.
REQ-016 Port state  output  3: current FSM encoding for debug.

Function
REQ-017 The FSM SHALL have four states: IDLE=000, SEND=001, GAP=010, DONE=011; encodings 100..111 SHALL recover to IDLE on the next edge.
REQ-018 IDLE with start=1 at edge k SHALL latch the pattern (per use_default), set reps_left=max(repeat_cnt,1), clear bit_idx, and enter SEND, so that x=pattern[PAT_W-1] and valid=1 from cycle k+1.
REQ-019 In SEND, each edge with tx_en=1 SHALL advance bit_idx by one and shift out the next bit; with tx_en=0, x, valid and bit_idx SHALL hold.
REQ-020 The edge that consumes the last bit (bit_idx=PAT_W-1, tx_en=1) SHALL do one of: (a) if reps_left>1, decrement reps_left and go to GAP, or straight to SEND with a pattern reload when GAP_CYCLES=0; (b) if reps_left=1, go to DONE.
REQ-021 GAP SHALL last exactly GAP_CYCLES edges with tx_en=1, holding x=0 and valid=0, then reload the latched pattern and enter SEND.
REQ-022 DONE SHALL last exactly one cycle with done=1, x=0, valid=0, busy=1, then go to IDLE.
REQ-023 start SHALL be ignored outside IDLE; latched pattern and repeat values SHALL NOT change mid-transmission.
REQ-024 abort=1 in SEND or GAP SHALL force IDLE on the next edge with x=0, valid=0, busy=0, and no done pulse; abort has priority over tx_en.
REQ-025 abort=1 and start=1 together in IDLE SHALL be ignored, and the block SHALL stay in IDLE.
REQ-026 In IDLE, x=0, valid=0, busy=0, done=0.
REQ-027 Total valid bit-times for a transmission SHALL equal PAT_W*max(repeat_cnt,1); total GAP bit-times SHALL equal GAP_CYCLES*(max(repeat_cnt,1)-1).

Reset
REQ-028 reset=0 SHALL immediately, without a clock edge, force state=000, x=0, valid=0, busy=0, done=0, bit_idx=0 and reps_left=0, including mid-SEND or mid-GAP.
REQ-029 After reset is released, the first start SHALL be accepted on the first rising edge at which reset=1.

Verification
REQ-030 use_default=1, repeat_cnt=1, tx_en=1, pulse start -> x=0,1,0,1,1,0 on 6 consecutive cycles with valid=1, then done=1 for exactly one cycle, then IDLE.
REQ-031 pattern_in=6'b111001, use_default=0, repeat_cnt=2, GAP_CYCLES=2 -> 111001, 2 cycles of valid=0, 111001, then done.
REQ-032 tx_en held low for 3 cycles after the 2nd bit -> x holds bit 2 for 4 cycles; the full sequence is otherwise unchanged; total busy cycles increase by 3.
REQ-033 abort during the 4th bit of repetition 1 of 3 -> IDLE next cycle, no done pulse, and a new start is accepted afterwards.
REQ-034 reset asserted mid-SEND between clock edges -> all outputs 0 immediately; start pulses during busy are ignored and do not alter the latched pattern.
REQ-035 repeat_cnt=0 -> exactly one pattern is sent; loopback into the 010110 detector yields exactly one detection per default-pattern repetition.
